// File: rtl/line_burst_rd_scheduler.sv
// line_burst_rd_scheduler: walks a rows x line_len frame in DDR with a programmable
// row stride and issues read bursts only when the downstream line FIFO can take the
// whole burst plus one spare word. Beats past the requested length never reach the FIFO.
// Optional build macro: LINE_BURST_BOUNDARY_SPLIT_EN clips every burst so it never
// crosses a 2^BOUNDARY_BITS-word boundary.
module line_burst_rd_scheduler #(
    parameter int ADDR_BITS     = 25,
    parameter int LEN_BITS      = 10,
    parameter int MAX_BURST     = 128,
    parameter int LINE_BITS     = 24,
    parameter int ROW_BITS      = 12,
    parameter int FIFO_AW       = 9,
    parameter int BOUNDARY_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] cfg_base,
    input  logic [LINE_BITS-1:0] cfg_line_len,
    input  logic [ROW_BITS-1:0]  cfg_rows,
    input  logic [ADDR_BITS-1:0] cfg_stride,
    input  logic [FIFO_AW:0]     fifo_wrusedw,
    output logic                 fifo_wr,
    output logic                 busy,
    output logic                 line_done,
    output logic                 frame_done,
    output logic                 frame_aborted,
    output logic                 rd_burst_req,
    output logic [LEN_BITS-1:0]  rd_burst_len,
    output logic [ADDR_BITS-1:0] rd_burst_addr,
    input  logic                 rd_burst_data_valid,
    input  logic                 rd_burst_finish
);

    if (MAX_BURST < 1 || MAX_BURST > (2 ** LEN_BITS) - 1 || BOUNDARY_BITS < 1) begin : g_param_check
        $error("line_burst_rd_scheduler: illegal parameter set");
    end

    localparam int ROOM_W = FIFO_AW + 2;
    localparam logic [ROOM_W-1:0] DEPTH = {2'b01, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, LINE_START, WAIT_SPACE, REQ, DATA, BURST_END, LINE_END, DONE
    } state_t;

    state_t state, state_nxt;

    logic [LINE_BITS-1:0] line_len_q;
    logic [ROW_BITS-1:0]  rows_q;
    logic [ADDR_BITS-1:0] stride_q;
    logic [ADDR_BITS-1:0] row_base;
    logic [ROW_BITS-1:0]  row_cnt;
    logic [LINE_BITS-1:0] remain;
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]  cur_len;
    logic [LEN_BITS-1:0]  beat_cnt;
    logic                 abort_lat;
    logic                 abort_any;

    logic [LINE_BITS-1:0] len_cap;
    logic [ROOM_W-1:0]    used_ext;
    logic [ROOM_W-1:0]    room;
    logic                 space_ok;
`ifdef LINE_BURST_BOUNDARY_SPLIT_EN
    logic [BOUNDARY_BITS:0] bnd_room;
`endif

    assign abort_any     = abort_lat | abort;
    assign rd_burst_req  = (state == REQ);
    assign rd_burst_len  = cur_len;
    assign rd_burst_addr = addr;
    assign busy          = (state != IDLE) && (state != DONE);
    assign fifo_wr       = rd_burst_data_valid && ((state == REQ) || (state == DATA))
                           && (beat_cnt < cur_len);

    // Size of the next burst and whether the FIFO can absorb it with one word to spare.
    always_comb begin
        len_cap = remain;
        if (remain > LINE_BITS'(MAX_BURST)) begin
            len_cap = LINE_BITS'(MAX_BURST);
        end
`ifdef LINE_BURST_BOUNDARY_SPLIT_EN
        bnd_room = {1'b1, {BOUNDARY_BITS{1'b0}}} - {1'b0, addr[BOUNDARY_BITS-1:0]};
        if (LINE_BITS'(bnd_room) < len_cap) begin
            len_cap = LINE_BITS'(bnd_room);
        end
`endif
        used_ext = {1'b0, fifo_wrusedw};
        room     = DEPTH - used_ext;
        space_ok = (used_ext < DEPTH) && (32'(room) > 32'(len_cap));
    end

    // Next-state decode; pending abort wins at the two safe exit points.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (cfg_line_len == '0 || cfg_rows == '0) ? DONE : LINE_START;
                end
            end
            LINE_START: state_nxt = WAIT_SPACE;
            WAIT_SPACE: begin
                if (abort_any) begin
                    state_nxt = DONE;
                end else if (space_ok) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rd_burst_finish) begin
                    state_nxt = BURST_END;
                end else if (rd_burst_data_valid) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (rd_burst_finish) begin
                    state_nxt = BURST_END;
                end
            end
            BURST_END: begin
                if (abort_any) begin
                    state_nxt = DONE;
                end else if (remain == LINE_BITS'(cur_len)) begin
                    state_nxt = LINE_END;
                end else begin
                    state_nxt = WAIT_SPACE;
                end
            end
            LINE_END: begin
                state_nxt = (row_cnt + ROW_BITS'(1) == rows_q) ? DONE : LINE_START;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, frame walk counters and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            line_len_q    <= '0;
            rows_q        <= '0;
            stride_q      <= '0;
            row_base      <= '0;
            row_cnt       <= '0;
            remain        <= '0;
            addr          <= '0;
            cur_len       <= '0;
            beat_cnt      <= '0;
            abort_lat     <= 1'b0;
            line_done     <= 1'b0;
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
        end else begin
            state         <= state_nxt;
            line_done     <= (state == LINE_END);
            frame_done    <= (state == DONE) && !abort_lat;
            frame_aborted <= (state == DONE) && abort_lat;

            if (state == IDLE) begin
                if (start) begin
                    abort_lat <= abort;
                end
            end else if (abort) begin
                abort_lat <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        line_len_q <= cfg_line_len;
                        rows_q     <= cfg_rows;
                        stride_q   <= cfg_stride;
                        row_base   <= cfg_base;
                        row_cnt    <= '0;
                    end
                end
                LINE_START: begin
                    remain <= line_len_q;
                    addr   <= row_base;
                end
                WAIT_SPACE: begin
                    cur_len  <= LEN_BITS'(len_cap);
                    beat_cnt <= '0;
                end
                REQ, DATA: begin
                    if (rd_burst_data_valid && (beat_cnt < cur_len)) begin
                        beat_cnt <= beat_cnt + LEN_BITS'(1);
                    end
                end
                BURST_END: begin
                    addr   <= addr + ADDR_BITS'(cur_len);
                    remain <= remain - LINE_BITS'(cur_len);
                end
                LINE_END: begin
                    row_base <= row_base + stride_q;
                    row_cnt  <= row_cnt + ROW_BITS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/line_burst_rd_scheduler.md
Name: line_burst_rd_scheduler

Overview:
- Parametrised single-clock read scheduler that walks a 2-D frame in DDR (rows × line length, programmable row stride) and issues read bursts to the DDR burst controller.
- Bursts are issued only when the downstream line FIFO has room for the whole burst. Beats beyond the requested length are gated out of the FIFO write.
- Sits between the frame-buffer read control and the out-FIFO write side. Generalises the fixed-burst, fixed-row-step reader with variable burst size, arbitrary stride, abort and an optional boundary split.

Parameters:
ADDR_BITS, 25, DDR word-address width
LEN_BITS, 10, burst length field width
MAX_BURST, 128, largest burst issued (1..2^LEN_BITS-1)
LINE_BITS, 24, line-length field width (words)
ROW_BITS, 12, row-count field width
FIFO_AW, 9, log2 of downstream FIFO depth
BOUNDARY_BITS, 8, log2 of split boundary (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle frame start; ignored while busy
abort  in  1  one-cycle request to stop the frame early
cfg_base  in  ADDR_BITS  frame start address, sampled on start
cfg_line_len  in  LINE_BITS  words per row, sampled on start
cfg_rows  in  ROW_BITS  rows per frame, sampled on start
cfg_stride  in  ADDR_BITS  address step between row starts, sampled on start
fifo_wrusedw  in  FIFO_AW+1  downstream FIFO fill level, in words
fifo_wr  out  1  FIFO write enable (rd_burst_data_valid gated)
busy  out  1  frame in progress
line_done  out  1  one-cycle pulse after the last burst of each row
frame_done  out  1  one-cycle pulse, frame completed normally
frame_aborted  out  1  one-cycle pulse, frame ended by abort
rd_burst_req  out  1  burst request
rd_burst_len  out  LEN_BITS  burst length, in words
rd_burst_addr  out  ADDR_BITS  burst start address
rd_burst_data_valid  in  1  read beat valid
rd_burst_finish  in  1  burst complete

Behaviour:
- Reset: every output is 0, state is IDLE, all config registers are cleared. Reset has priority over all inputs. Reset asserted mid-burst drops rd_burst_req on the next edge; any remaining beats are not written (fifo_wr=0).
- States: IDLE, LINE_START, WAIT_SPACE, REQ, DATA, BURST_END, LINE_END, DONE.
- IDLE: on start, latch cfg_*; row_base=cfg_base; row_cnt=0; busy=1 from the next cycle.
  - If cfg_line_len==0 or cfg_rows==0, go to DONE; frame_done pulses 2 cycles after start and no burst is issued.
  - Otherwise go to LINE_START.
- LINE_START: remain=cfg_line_len; addr=row_base; go to WAIT_SPACE.
- WAIT_SPACE: compute cur_len=min(remain, MAX_BURST).
  - Go to REQ when (2^FIFO_AW - fifo_wrusedw) > cur_len, i.e. at least one spare word beyond the burst.
- REQ: rd_burst_req=1, with rd_burst_len=cur_len and rd_burst_addr=addr held stable.
  - rd_burst_req deasserts on the cycle after the first rd_burst_data_valid; go to DATA.
- DATA: wait for rd_burst_finish, then go to BURST_END.
- Beat gating in REQ and DATA: beat counter cleared on entry to REQ. fifo_wr = rd_burst_data_valid && beat_cnt < cur_len, so overrun beats (e.g. the even-rounding extra beat) are dropped.
- BURST_END: addr += cur_len; remain -= cur_len.
  - remain==0 → LINE_END.
  - Otherwise → WAIT_SPACE.
- LINE_END: line_done pulses; row_base += cfg_stride; row_cnt++.
  - row_cnt+1==cfg_rows → DONE.
  - Otherwise → LINE_START.
- DONE: pulse frame_done, or frame_aborted if abort was latched; busy=0; return to IDLE.
- Earliest request latency: start at edge t → LINE_START t+1 → WAIT_SPACE t+2 → rd_burst_req high at t+3, given FIFO space.
- abort:
  - Latched in any non-IDLE state.
  - A burst already requested (REQ/DATA) runs to rd_burst_finish, since bursts cannot be cancelled.
  - The next BURST_END or WAIT_SPACE goes directly to DONE.
  - abort in IDLE is ignored.
  - abort coincident with start: the start is taken, then aborted; the frame ends with frame_aborted and no burst is issued.
- Arithmetic: all address sums wrap modulo 2^ADDR_BITS; a last burst shorter than MAX_BURST is legal.
- rd_burst_finish arriving without valid beats still ends the burst. Missing beats are not re-requested.

Optional Feature:
- Macro: LINE_BURST_BOUNDARY_SPLIT_EN.
- Defined: cur_len = min(remain, MAX_BURST, 2^BOUNDARY_BITS - addr[BOUNDARY_BITS-1:0]), so no burst crosses a 2^BOUNDARY_BITS word boundary.
- Undefined: no boundary clipping; BOUNDARY_BITS is unused.

Test Plan:
- base=0x100, line=300, rows=2, stride=0x400, FIFO empty → bursts (0x100,128), (0x180,128), (0x200,44), (0x500,128), (0x580,128), (0x600,44); line_done ×2; frame_done once.
- fifo_wrusedw=400 (FIFO_AW=9), line=128 → no request until wrusedw ≤383; then one request.
- Controller returns 12 beats for a len-11 burst → fifo_wr high for exactly 11 beats.
- abort during DATA of the first burst, line=300 → that burst completes; no further request; frame_aborted pulses; frame_done stays 0.
- start with cfg_rows=0 → no rd_burst_req; frame_done 2 cycles after start; start again while busy → ignored.
- With LINE_BURST_BOUNDARY_SPLIT_EN, base=0xF0, line=64 → bursts (0xF0,16), (0x100,48); rst asserted mid-burst → all outputs 0 on the next edge.
